// File: rtl/jt6295_pkg.sv
// Shared types and constants for the JT6295 ROM scheduler and the channel fetchers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package jt6295_pkg;
    localparam int NCH    = 4;    // ADPCM channels sharing the ROM port
    localparam int AW_DEF = 18;   // ROM byte-address width
    localparam int DW_DEF = 8;    // ROM data width

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACK
    } state_t;
endpackage

// File: rtl/jt6295_rom_sched_if.sv
// Requester and ROM-side signal bundle of the ROM scheduler.
// Latency: none (wires only).
// Backpressure: carried by the req/ack pairs and rom_ok.
// Ports: slave = scheduler view, master = requesters + ROM view.
interface jt6295_rom_sched_if
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic              cen_sr4;
    logic              ctl_req;
    logic [AW-1:0]     ctl_addr;
    logic              ctl_ack;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     dout;
    logic              ovr_clr;
    logic [NCH-1:0]    overrun;
    logic [AW-1:0]     rom_addr;
    logic              rom_cs;
    logic [DW-1:0]     rom_data;
    logic              rom_ok;

    modport slave (
        input  cen_sr4, ctl_req, ctl_addr, ch_req, ch_addr, ovr_clr, rom_data, rom_ok,
        output ctl_ack, ch_ack, dout, overrun, rom_addr, rom_cs
    );

    modport master (
        output cen_sr4, ctl_req, ctl_addr, ch_req, ch_addr, ovr_clr, rom_data, rom_ok,
        input  ctl_ack, ch_ack, dout, overrun, rom_addr, rom_cs
    );
endinterface

// File: rtl/jt6295_rr4.sv
// Combinational 4-way round-robin picker: first set req bit searching ptr, ptr+1, ... mod 4.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is taken and owns ptr.
// Ports: req[3:0], ptr[1:0] in; gnt_valid, gnt_idx[1:0] out.
module jt6295_rr4
    import jt6295_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     ptr,
    output logic           gnt_valid,
    output logic [1:0]     gnt_idx
);
    logic [1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        idx       = 2'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/jt6295_rom_sched.sv
// Shares one ROM read port between the control fetcher (priority) and 4 round-robin channels.
// Latency: req seen in IDLE -> ack 3 cycles later with rom_ok high (OKDLY=1); one access per 4 clk.
// Backpressure: rom_ok low stalls WAIT indefinitely; pending requesters simply hold req.
// Ports: clk, rst_n (async active-low), bus (slave modport: requests, acks, dout, overrun, ROM side).
module jt6295_rom_sched
    import jt6295_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int OKDLY = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    jt6295_rom_sched_if.slave  bus
);
    state_t         state, state_d;
    logic [1:0]     cnt;
    logic [1:0]     ptr;
    logic [1:0]     gnt_ch;
    logic           gnt_ctl;
    logic           rr_vld;
    logic [1:0]     rr_idx;
    logic           grant;
    logic           take;
    logic [AW-1:0]  rom_addr_q;
    logic           rom_cs_q;
    logic [DW-1:0]  dout_q;
    logic [NCH-1:0] ovr_q;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] ch_ack_c;

    jt6295_rr4 u_rr (
        .req       (bus.ch_req),
        .ptr       (ptr),
        .gnt_valid (rr_vld),
        .gnt_idx   (rr_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // rom_ok is only looked at in WAIT, which keeps the address-settle window blind to it.
    always_comb begin
        state_d = state;
        grant   = 1'b0;
        take    = 1'b0;
        case (state)
            IDLE:  if (bus.ctl_req || rr_vld) begin
                       grant   = 1'b1;
                       state_d = SETUP;
                   end
            SETUP: if (cnt == 2'd1) state_d = WAIT;
            WAIT:  if (bus.rom_ok) begin
                       take    = 1'b1;
                       state_d = ACK;
                   end
            ACK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            ptr        <= 2'd0;
            gnt_ch     <= 2'd0;
            gnt_ctl    <= 1'b0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            if (grant) begin
                gnt_ctl  <= bus.ctl_req;
                rom_cs_q <= 1'b1;
                cnt      <= 2'(OKDLY);
                if (bus.ctl_req) begin
                    rom_addr_q <= bus.ctl_addr;      // ptr untouched on a ctl grant
                end else begin
                    rom_addr_q <= bus.ch_addr[int'(rr_idx)*AW +: AW];
                    gnt_ch     <= rr_idx;
                    ptr        <= rr_idx + 2'd1;
                end
            end
            if (state == SETUP) cnt <= cnt - 2'd1;
            if (take) begin
                dout_q   <= bus.rom_data;
                rom_cs_q <= 1'b0;
            end
        end
    end

    // A channel being acked on the strobe edge made its slot; anyone else still requesting missed it.
    always_comb begin
        ovr_set = '0;
        for (int i = 0; i < NCH; i++) begin
            ovr_set[i] = bus.cen_sr4 & bus.ch_req[i] &
                         ~((state == ACK) && !gnt_ctl && (gnt_ch == 2'(i)));
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= '0;
        else        ovr_q <= (bus.ovr_clr ? '0 : ovr_q) | ovr_set;
    end

    always_comb begin
        ch_ack_c = '0;
        if (state == ACK && !gnt_ctl) ch_ack_c[gnt_ch] = 1'b1;
    end

    assign bus.ctl_ack  = (state == ACK) && gnt_ctl;
    assign bus.ch_ack   = ch_ack_c;
    assign bus.dout     = dout_q;
    assign bus.overrun  = ovr_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_cs   = rom_cs_q;
endmodule

// File: tb/tb_jt6295_rom_sched.sv
// Directed bench for the ROM scheduler: reset, round-robin, single access, rom_ok gating,
// ctl priority, overrun set/clear, and reset in the middle of an access.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_jt6295_rom_sched;
    import jt6295_pkg::*;

    localparam int AW = 18;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    jt6295_rom_sched_if #(.AW(AW), .DW(DW)) bus ();

    jt6295_rom_sched #(.AW(AW), .DW(DW), .OKDLY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running required done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ch_addr(input int ch, input logic [AW-1:0] a);
        bus.ch_addr[ch*AW +: AW] = a;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.cen_sr4  = 1'b0;
        bus.ctl_req  = 1'b0;
        bus.ctl_addr = '0;
        bus.ch_req   = '0;
        bus.ch_addr  = '0;
        bus.ovr_clr  = 1'b0;
        bus.rom_data = '0;
        bus.rom_ok   = 1'b1;

        // ---------------- reset state
        tick(); tick();
        chk("rst_rom_cs",   32'(bus.rom_cs),   32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_dout",     32'(bus.dout),     32'h0);
        chk("rst_ctl_ack",  32'(bus.ctl_ack),  32'h0);
        chk("rst_ch_ack",   32'(bus.ch_ack),   32'h0);
        chk("rst_overrun",  32'(bus.overrun),  32'h0);
        chk("rst_state",    32'(dut.state),    32'(IDLE));
        rst_n = 1'b1;
        tick();

        // ---------------- round-robin: all four request, ptr starts at 0
        for (int i = 0; i < 4; i++) set_ch_addr(i, 18'(32'h100 * i + 32'h10));
        bus.ch_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_addr%0d", i), 32'(bus.rom_addr), 32'h100 * i + 32'h10);
            bus.rom_data = 8'(8'hC0 + i);
            tick();
            chk($sformatf("rr_noack%0d", i), 32'(bus.ch_ack), 32'h0);
            tick();
            chk($sformatf("rr_ack%0d", i),  32'(bus.ch_ack), 32'h1 << i);
            chk($sformatf("rr_dout%0d", i), 32'(bus.dout),   32'hC0 + i);
            bus.ch_req[i] = 1'b0;
            tick();
        end
        chk("rr_ptr_wrap", 32'(dut.ptr), 32'h0);

        // ---------------- single access on ch2
        set_ch_addr(2, 18'h01234);
        bus.ch_req   = 4'b0100;
        bus.rom_data = 8'h5A;
        tick();   // cycle 1
        chk("sa_cs1",   32'(bus.rom_cs),   32'h1);
        chk("sa_addr1", 32'(bus.rom_addr), 32'h01234);
        tick();   // cycle 2
        chk("sa_cs2",   32'(bus.rom_cs),   32'h1);
        chk("sa_ack2",  32'(bus.ch_ack),   32'h0);
        tick();   // cycle 3
        chk("sa_ack3",  32'(bus.ch_ack),   32'h4);
        chk("sa_dout3", 32'(bus.dout),     32'h5A);
        chk("sa_cs3",   32'(bus.rom_cs),   32'h0);
        bus.ch_req = 4'b0000;
        tick();   // cycle 4
        chk("sa_ack4",  32'(bus.ch_ack),   32'h0);
        chk("sa_dout4", 32'(bus.dout),     32'h5A);
        chk("sa_state4", 32'(dut.state),   32'(IDLE));

        // ---------------- rom_ok gating on ch0 (ptr=3, search 3 then 0)
        set_ch_addr(0, 18'h00321);
        bus.ch_req   = 4'b0001;
        bus.rom_data = 8'h77;
        tick();   // cycle 1, SETUP: rom_ok high here must be ignored
        chk("ok_addr", 32'(bus.rom_addr), 32'h00321);
        tick();   // cycle 2, WAIT
        chk("ok_setup_ignored", 32'(bus.ch_ack), 32'h0);
        bus.rom_ok = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            tick();
            chk($sformatf("ok_hold%0d", c), 32'(bus.ch_ack), 32'h0);
        end
        chk("ok_cs_held", 32'(bus.rom_cs), 32'h1);
        bus.rom_ok = 1'b1;
        tick();   // cycle 8
        chk("ok_ack",  32'(bus.ch_ack), 32'h1);
        chk("ok_dout", 32'(bus.dout),   32'h77);
        bus.ch_req = 4'b0000;
        tick();
        chk("ok_ptr", 32'(dut.ptr), 32'h1);

        // ---------------- priority: ctl raised during ch1 access while ch3 waits
        set_ch_addr(1, 18'h0AAAA);
        set_ch_addr(3, 18'h3FFFF);
        bus.ch_req   = 4'b0010;
        bus.rom_data = 8'h11;
        tick();   // cycle 1
        chk("pr_addr_ch1", 32'(bus.rom_addr), 32'h0AAAA);
        bus.ch_req[3] = 1'b1;
        bus.ctl_req   = 1'b1;
        bus.ctl_addr  = 18'h2BEEF;
        tick();   // cycle 2
        tick();   // cycle 3
        chk("pr_ack_ch1", 32'(bus.ch_ack),  32'h2);
        chk("pr_noctl",   32'(bus.ctl_ack), 32'h0);
        chk("pr_dout1",   32'(bus.dout),    32'h11);
        bus.ch_req[1] = 1'b0;
        bus.rom_data  = 8'h22;
        tick();   // cycle 4, IDLE
        tick();   // cycle 5
        chk("pr_addr_ctl", 32'(bus.rom_addr), 32'h2BEEF);
        chk("pr_ptr_ctl",  32'(dut.ptr),      32'h2);
        tick(); tick();   // cycle 7
        chk("pr_ctl_ack", 32'(bus.ctl_ack), 32'h1);
        chk("pr_ctl_chk", 32'(bus.ch_ack),  32'h0);
        chk("pr_dout2",   32'(bus.dout),    32'h22);
        bus.ctl_req  = 1'b0;
        bus.rom_data = 8'h33;
        tick();   // cycle 8, IDLE
        tick();   // cycle 9
        chk("pr_addr_ch3", 32'(bus.rom_addr), 32'h3FFFF);
        tick(); tick();   // cycle 11
        chk("pr_ack_ch3", 32'(bus.ch_ack), 32'h8);
        chk("pr_dout3",   32'(bus.dout),   32'h33);
        bus.ch_req = 4'b0000;
        tick();
        chk("pr_ptr_end", 32'(dut.ptr), 32'h0);

        // ---------------- overrun on ch0
        set_ch_addr(0, 18'h00055);
        bus.ch_req = 4'b0001;
        bus.rom_ok = 1'b0;
        tick(); tick(); tick();   // cycle 3, WAIT
        bus.cen_sr4 = 1'b1;
        tick();   // cycle 4
        bus.cen_sr4 = 1'b0;
        chk("ov_set", 32'(bus.overrun), 32'h1);
        tick();   // cycle 5
        chk("ov_sticky", 32'(bus.overrun), 32'h1);
        bus.cen_sr4 = 1'b1;
        bus.ovr_clr = 1'b1;
        tick();   // cycle 6
        chk("ov_set_wins", 32'(bus.overrun), 32'h1);
        bus.cen_sr4 = 1'b0;
        tick();   // cycle 7
        chk("ov_clr", 32'(bus.overrun), 32'h0);
        bus.ovr_clr = 1'b0;
        bus.rom_ok  = 1'b1;
        tick();   // cycle 8, ACK for ch0: strobe here is a made slot
        chk("ov_ack", 32'(bus.ch_ack), 32'h1);
        bus.cen_sr4 = 1'b1;
        tick();   // cycle 9
        bus.cen_sr4 = 1'b0;
        bus.ch_req  = 4'b0000;
        chk("ov_ack_slot_ok", 32'(bus.overrun), 32'h0);

        // ---------------- reset during WAIT on ch2 (ptr=1)
        set_ch_addr(2, 18'h01357);
        bus.ch_req = 4'b0100;
        bus.rom_ok = 1'b0;
        tick();   // cycle 1
        tick();   // cycle 2
        bus.cen_sr4 = 1'b1;
        tick();   // cycle 3, WAIT
        bus.cen_sr4 = 1'b0;
        chk("mr_pre_cs",  32'(bus.rom_cs),  32'h1);
        chk("mr_pre_ovr", 32'(bus.overrun), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mr_cs",    32'(bus.rom_cs),  32'h0);
        chk("mr_ack",   32'(bus.ch_ack),  32'h0);
        chk("mr_state", 32'(dut.state),   32'(IDLE));
        chk("mr_ovr",   32'(bus.overrun), 32'h0);
        tick();   // cycle 4, still in reset
        chk("mr_noack", 32'(bus.ch_ack), 32'h0);
        rst_n        = 1'b1;
        bus.rom_ok   = 1'b1;
        bus.rom_data = 8'h99;
        tick();   // cycle 5
        chk("mr_regrant_cs",   32'(bus.rom_cs),   32'h1);
        chk("mr_regrant_addr", 32'(bus.rom_addr), 32'h01357);
        tick(); tick();   // cycle 7
        chk("mr_regrant_ack",  32'(bus.ch_ack), 32'h4);
        chk("mr_regrant_dout", 32'(bus.dout),   32'h99);
        bus.ch_req = 4'b0000;
        tick();
        chk("mr_idle", 32'(dut.state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
